// File: rtl/fa_serial_ctrl.sv
// Bit-serial add/subtract sequencer: one registered full-adder cell stepped
// LSB-first over WIDTH clocks, with valid/ready handshakes on both sides.
module fa_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             step;
    logic             last_step;
    logic             fa_s;
    logic             fa_c;

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // State register
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = RUN;
            RUN:  if (cnt_q == LAST_BIT) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state only, so in_ready never depends on in_valid
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: in_ready = 1'b1;
            RUN:  busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign step      = (state_q == RUN);
    assign last_step = step & (cnt_q == LAST_BIT);
    assign fa_s      = fa_sum(a_q[0], b_q[0], carry_q);
    assign fa_c      = fa_carry(a_q[0], b_q[0], carry_q);

    // Datapath next state: operands shift right, sum fills from the MSB end
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = op_a;
            b_d     = sub ? ~op_b : op_b;
            carry_d = sub;
            cnt_d   = '0;
        end else if (step) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_c;
            cnt_d   = cnt_q + CNT_W'(1);
            sum_d   = {fa_s, sum_q[WIDTH-1:1]};
            if (last_step) begin
                cout_d = fa_c;
                ovf_d  = carry_q ^ fa_c;
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand shifters are fully reloaded on every accept, so they need no reset
    always_ff @(posedge ck) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Scoreboard bench for fa_serial_ctrl: expected results are queued on accept
// and compared when the output handshake completes.
module tb_fa_serial_ctrl;

    localparam int unsigned W = 8;

    logic         ck;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_results = 0;
    int acc_edge = 0;
    int last_acc = 0;
    int b2b_cnt  = 0;
    bit b2b      = 0;
    bit prev_ov  = 0;

    logic [W+1:0] sb[$];

    fa_serial_ctrl #(.WIDTH(W)) dut (
        .ck        (ck),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference built from signed/unsigned integer arithmetic: {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        longint sa, sb_v, ua, ub, tr;
        logic [W-1:0] r;
        logic co, ov;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb_v = longint'($signed(b));
        if (s) begin
            r  = W'(ua - ub);
            co = (ua >= ub);
            tr = sa - sb_v;
        end else begin
            r  = W'(ua + ub);
            co = ((ua + ub) >= (longint'(1) << W));
            tr = sa + sb_v;
        end
        ov = (tr > ((longint'(1) << (W - 1)) - 1)) || (tr < -(longint'(1) << (W - 1)));
        return {ov, co, r};
    endfunction

    // Monitor: sample on the falling edge, inputs are driven 1 unit after the rising edge
    always @(negedge ck) begin
        logic [W+1:0] e;
        if (rst) begin
            sb.delete();
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov)
                chk("latency", 64'(cyc - acc_edge), 64'(W));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    chk("res_sum",  64'(sum),  64'(e[W-1:0]));
                    chk("res_cout", 64'(cout), 64'(e[W]));
                    chk("res_ovf",  64'(ovf),  64'(e[W+1]));
                end
                n_results++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(op_a, op_b, sub));
                if (b2b) begin
                    if (b2b_cnt > 0)
                        chk("ii_spacing", 64'(cyc + 1 - last_acc), 64'(W + 2));
                    b2b_cnt++;
                end else begin
                    b2b_cnt = 0;
                end
                acc_edge = cyc + 1;
                last_acc = cyc + 1;
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int k;
        @(posedge ck);
        #1;
        op_a = a;
        op_b = b;
        sub = s;
        in_valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge ck);
            if (in_ready) break;
        end
        chk("accept_wait", 64'(in_ready), 64'd1);
        @(posedge ck);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge ck);
            if (in_ready && !out_valid && sb.size() == 0) break;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [W+1:0] e;
        int k;
        int r0;
        rst = 1'b1;
        in_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        sub = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge ck);
        @(negedge ck);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_sum",       64'(sum),       64'd0);
        chk("rst_cout",      64'(cout),      64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        @(posedge ck);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        send(8'h5A, 8'h3C, 1'b0);
        wait_idle("t1_done");
        send(8'hFF, 8'h01, 1'b0);
        wait_idle("t2a_done");
        send(8'h80, 8'h01, 1'b1);
        wait_idle("t2b_done");

        // Operand changes during RUN must not affect the result
        send(8'h10, 8'h20, 1'b1);
        repeat (4) begin
            @(posedge ck);
            #1;
            op_a = W'($urandom);
            op_b = W'($urandom);
            sub = ~sub;
        end
        wait_idle("t3_done");

        // Backpressure in DONE
        out_ready = 1'b0;
        send(8'h7F, 8'h01, 1'b0);
        e = model(8'h7F, 8'h01, 1'b0);
        for (k = 0; k < 50; k++) begin
            @(negedge ck);
            if (out_valid) break;
        end
        chk("bp_out_valid_rise", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge ck);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_sum",  64'(sum),  64'(e[W-1:0]));
            chk("bp_cout", 64'(cout), 64'(e[W]));
            chk("bp_ovf",  64'(ovf),  64'(e[W+1]));
        end
        @(posedge ck);
        #1;
        out_ready = 1'b1;
        @(negedge ck);
        @(negedge ck);
        chk("bp_release_in_ready",  64'(in_ready),  64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of RUN
        r0 = n_results;
        send(8'hFF, 8'hFF, 1'b0);
        repeat (3) @(posedge ck);
        #1;
        rst = 1'b1;
        @(posedge ck);
        #1;
        rst = 1'b0;
        @(negedge ck);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy",      64'(busy),      64'd0);
        chk("midrst_sum",       64'(sum),       64'd0);
        send(8'h01, 8'h01, 1'b0);
        wait_idle("t5_done");
        chk("midrst_results", 64'(n_results - r0), 64'd1);

        // Random sweep
        for (int i = 0; i < 6; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            wait_idle("rand_done");
        end

        // Back-to-back with in_valid held high
        b2b = 1'b1;
        @(posedge ck);
        #1;
        op_a = 8'hC3;
        op_b = 8'h3D;
        sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (k = 0; k < 50; k++) begin
                @(negedge ck);
                if (in_ready) break;
            end
            chk("b2b_accept", 64'(in_ready), 64'd1);
            @(posedge ck);
            #1;
            op_a = W'($urandom);
            op_b = W'($urandom);
            sub = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        wait_idle("b2b_done");
        chk("b2b_count", 64'(b2b_cnt), 64'd4);
        b2b = 1'b0;

        repeat (3) @(posedge ck);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
